// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : RV32I decode/issue stage in front of the clocked ALU. Decodes one
//            instruction per valid/ready handshake into an ALU opcode, two
//            operands and writeback/control sidebands, then holds the result
//            in a single output register so the ALU always sees stable inputs.
// Ports    : clock, reset_n (async, active low), flush (sync kill)
//            in_valid/in_ready, in_instr, in_pc, rs1_data, rs2_data
//            out_valid/out_ready, alu_op, alu_a, alu_b, out_rd, wb_en,
//            wb_from_cond, is_branch/is_jal/is_jalr/is_load/is_store,
//            store_data, imm, out_pc, illegal
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int          XLEN     = 32,            // only 32 is supported
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      out_rd,
    output logic            wb_en,
    output logic            wb_from_cond,
    output logic            is_branch,
    output logic            is_jal,
    output logic            is_jalr,
    output logic            is_load,
    output logic            is_store,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] out_pc,
    output logic            illegal
);

    // ALU opcode encoding shared with the execute stage
    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_SUB = 4'd1;
    localparam logic [3:0] c_ALU_SLL = 4'd2;
    localparam logic [3:0] c_ALU_LT  = 4'd3;
    localparam logic [3:0] c_ALU_LTU = 4'd4;
    localparam logic [3:0] c_ALU_XOR = 4'd5;
    localparam logic [3:0] c_ALU_SRL = 4'd6;
    localparam logic [3:0] c_ALU_SRA = 4'd7;
    localparam logic [3:0] c_ALU_OR  = 4'd8;
    localparam logic [3:0] c_ALU_AND = 4'd9;
    localparam logic [3:0] c_ALU_EQ  = 4'd10;
    localparam logic [3:0] c_ALU_NE  = 4'd11;
    localparam logic [3:0] c_ALU_GE  = 4'd12;
    localparam logic [3:0] c_ALU_GEU = 4'd13;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // ------------------------------------------------------------------------
    // Field extraction and immediates
    // ------------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_rd     = in_instr[11:7];
    assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u  = {in_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
    assign w_shamt  = {27'b0, in_instr[24:20]};

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_a, w_b, w_imm, w_sd;
    logic [4:0]      w_rd_out;
    logic            w_wb, w_cond, w_br, w_jal, w_jalr, w_ld, w_st, w_ill;

    always_comb begin
        w_op     = c_ALU_ADD;
        w_a      = '0;
        w_b      = '0;
        w_imm    = '0;
        w_sd     = '0;
        w_rd_out = w_rd;
        w_wb     = 1'b0;
        w_cond   = 1'b0;
        w_br     = 1'b0;
        w_jal    = 1'b0;
        w_jalr   = 1'b0;
        w_ld     = 1'b0;
        w_st     = 1'b0;
        w_ill    = 1'b0;

        case (w_opcode)
            c_OPC_OP: begin
                w_a  = rs1_data;
                w_b  = rs2_data;
                w_wb = 1'b1;
                // Only SUB and SRA use the alternate funct7; all else need 0
                if (!((w_f7 == c_F7_ZERO) ||
                      (w_f7 == c_F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                    w_ill = 1'b1;
                case (w_f3)
                    3'b000: w_op = (w_f7 == c_F7_ALT) ? c_ALU_SUB : c_ALU_ADD;
                    3'b001: begin w_op = c_ALU_SLL; w_b = rs2_data & 32'h1F; end
                    3'b010: begin w_op = c_ALU_LT;  w_cond = 1'b1; end
                    3'b011: begin w_op = c_ALU_LTU; w_cond = 1'b1; end
                    3'b100: w_op = c_ALU_XOR;
                    3'b101: begin
                        w_op = (w_f7 == c_F7_ALT) ? c_ALU_SRA : c_ALU_SRL;
                        w_b  = rs2_data & 32'h1F;
                    end
                    3'b110: w_op = c_ALU_OR;
                    default: w_op = c_ALU_AND;
                endcase
            end
            c_OPC_OPIMM: begin
                w_a   = rs1_data;
                w_b   = w_imm_i;
                w_imm = w_imm_i;
                w_wb  = 1'b1;
                case (w_f3)
                    3'b000: w_op = c_ALU_ADD;
                    3'b001: begin
                        w_op  = c_ALU_SLL;
                        w_b   = w_shamt;
                        w_ill = (w_f7 != c_F7_ZERO);
                    end
                    3'b010: begin w_op = c_ALU_LT;  w_cond = 1'b1; end
                    3'b011: begin w_op = c_ALU_LTU; w_cond = 1'b1; end
                    3'b100: w_op = c_ALU_XOR;
                    3'b101: begin
                        w_op  = (w_f7 == c_F7_ALT) ? c_ALU_SRA : c_ALU_SRL;
                        w_b   = w_shamt;
                        w_ill = (w_f7 != c_F7_ZERO) && (w_f7 != c_F7_ALT);
                    end
                    3'b110: w_op = c_ALU_OR;
                    default: w_op = c_ALU_AND;
                endcase
            end
            c_OPC_LUI: begin
                w_b   = w_imm_u;
                w_imm = w_imm_u;
                w_wb  = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_a   = in_pc;
                w_b   = w_imm_u;
                w_imm = w_imm_u;
                w_wb  = 1'b1;
            end
            c_OPC_JAL: begin
                // ALU computes the link address; the target uses imm + pc
                w_a   = in_pc;
                w_b   = 32'd4;
                w_imm = w_imm_j;
                w_jal = 1'b1;
                w_wb  = 1'b1;
            end
            c_OPC_JALR: begin
                w_a    = in_pc;
                w_b    = 32'd4;
                w_imm  = w_imm_i;
                w_jalr = 1'b1;
                w_wb   = 1'b1;
                w_ill  = (w_f3 != 3'b000);
            end
            c_OPC_BRANCH: begin
                w_a      = rs1_data;
                w_b      = rs2_data;
                w_imm    = w_imm_b;
                w_br     = 1'b1;
                w_rd_out = '0;
                case (w_f3)
                    3'b000:  w_op = c_ALU_EQ;
                    3'b001:  w_op = c_ALU_NE;
                    3'b100:  w_op = c_ALU_LT;
                    3'b101:  w_op = c_ALU_GE;
                    3'b110:  w_op = c_ALU_LTU;
                    3'b111:  w_op = c_ALU_GEU;
                    default: w_ill = 1'b1;
                endcase
            end
            c_OPC_LOAD: begin
                w_a   = rs1_data;
                w_b   = w_imm_i;
                w_imm = w_imm_i;
                w_ld  = 1'b1;
                w_wb  = 1'b1;
            end
            c_OPC_STORE: begin
                w_a      = rs1_data;
                w_b      = w_imm_s;
                w_imm    = w_imm_s;
                w_sd     = rs2_data;
                w_st     = 1'b1;
                w_rd_out = '0;
            end
            default: w_ill = 1'b1;
        endcase

        // Illegal encodings travel as an inert ADD 0,0 carrying only the flag
        if (w_ill) begin
            w_op     = c_ALU_ADD;
            w_a      = '0;
            w_b      = '0;
            w_imm    = '0;
            w_sd     = '0;
            w_rd_out = '0;
            w_wb     = 1'b0;
            w_cond   = 1'b0;
            w_br     = 1'b0;
            w_jal    = 1'b0;
            w_jalr   = 1'b0;
            w_ld     = 1'b0;
            w_st     = 1'b0;
        end

        // x0 is never written
        if (w_rd_out == 5'd0)
            w_wb = 1'b0;
    end

    // ------------------------------------------------------------------------
    // Output pipeline register
    // ------------------------------------------------------------------------
    logic w_accept;

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            alu_op       <= c_ALU_ADD;
            alu_a        <= '0;
            alu_b        <= '0;
            out_rd       <= '0;
            wb_en        <= 1'b0;
            wb_from_cond <= 1'b0;
            is_branch    <= 1'b0;
            is_jal       <= 1'b0;
            is_jalr      <= 1'b0;
            is_load      <= 1'b0;
            is_store     <= 1'b0;
            store_data   <= '0;
            imm          <= '0;
            out_pc       <= RESET_PC;
            illegal      <= 1'b0;
        end else if (flush) begin
            // Redirect kills both the held and any same-cycle instruction
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid    <= 1'b1;
            alu_op       <= w_op;
            alu_a        <= w_a;
            alu_b        <= w_b;
            out_rd       <= w_rd_out;
            wb_en        <= w_wb;
            wb_from_cond <= w_cond;
            is_branch    <= w_br;
            is_jal       <= w_jal;
            is_jalr      <= w_jalr;
            is_load      <= w_ld;
            is_store     <= w_st;
            store_data   <= w_sd;
            imm          <= w_imm;
            out_pc       <= in_pc;
            illegal      <= w_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the clocked ALU. Takes one fetched RV32I instruction per handshake plus its register-file read data and PC.
- Decodes the instruction into an ALU opcode (the `ADD/`SUB/... codes in codes.v) and two 32-bit operands, together with writeback and control sidebands.
- Holds the result in a single pipeline register with a valid/ready handshake, so the ALU always sees stable operands.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- RESET_PC, 32'h0000_0000, reset value of out_pc.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the held and incoming instruction (branch/jump redirect).
- in_valid  in  1  instruction, pc, rs1_data and rs2_data are valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  RV32I instruction word.
- in_pc  in  32  PC of in_instr.
- rs1_data  in  32  register-file value of in_instr[19:15]; x0 reads as 0.
- rs2_data  in  32  register-file value of in_instr[24:20].
- out_valid  out  1  output register holds a live instruction.
- out_ready  in  1  ALU/execute consumes this cycle.
- alu_op  out  4  codes.v opcode.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- out_rd  out  5  destination register.
- wb_en  out  1  writes rd; forced 0 when rd==0.
- wb_from_cond  out  1  writeback value is zero-extended ALU cond (SLT/SLTU/SLTI/SLTIU).
- is_branch, is_jal, is_jalr, is_load, is_store  out  1 each  class flags.
- store_data  out  32  rs2_data for stores, else 0.
- imm  out  32  sign-extended immediate (branch/jump target computation).
- out_pc  out  32  PC of the held instruction.
- illegal  out  1  unsupported opcode or funct encoding.

Behaviour:
- Reset (async, reset_n low): out_valid=0; alu_op=`ADD; alu_a=alu_b=imm=store_data=0; out_rd=0; all flags=0; out_pc=RESET_PC. Reset mid-transfer drops the held instruction with no partial state.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept occurs when in_valid && in_ready. On the next edge the output register loads the decode and out_valid=1. Latency is 1 cycle.
- If out_valid && !out_ready, every output holds stable.
- Consume without a new accept: out_valid falls to 0. Simultaneous consume and accept: the new instruction loads and out_valid stays 1, giving back-to-back throughput of 1 per cycle.
- flush=1 at an edge: out_valid=0 and any same-cycle accept is discarded. flush has priority over accept. in_ready is unaffected by flush.
- Decode by opcode:
  - OP: a=rs1, b=rs2. funct7/funct3 map to ADD, SUB, SLL, SLT→LT, SLTU→LTU, XOR, SRL, SRA, OR, AND. For shifts, b=rs2&32'h1F.
  - OP-IMM: a=rs1, b=I-imm. SLLI/SRLI/SRAI use b={27'b0,shamt}. SLLI/SRLI require funct7=0 and SRAI requires 0100000, otherwise illegal.
  - LUI: `ADD, a=0, b=U-imm.
  - AUIPC: `ADD, a=pc, b=U-imm.
  - JAL: `ADD, a=pc, b=4, imm=J-imm, is_jal.
  - JALR: `ADD, a=pc, b=4, imm=I-imm, is_jalr, wb_en; funct3 must be 0.
  - BRANCH: a=rs1, b=rs2, wb_en=0, imm=B-imm, is_branch. BEQ→EQ, BNE→NE, BLT→LT, BGE→GE, BLTU→LTU, BGEU→GEU. funct3 010/011 are illegal.
  - LOAD: `ADD, a=rs1, b=I-imm, is_load, wb_en.
  - STORE: `ADD, a=rs1, b=S-imm, store_data=rs2, wb_en=0.
- Illegal encoding: illegal=1, wb_en=0, all class flags 0, alu_op=`ADD, a=b=0. The stage still presents it as out_valid=1 so the trap path sees it.
- Immediates are sign-extended from bit 31. U-imm is {instr[31:12],12'b0}.
- wb_from_cond=1 only for SLT/SLTU/SLTI/SLTIU.

Test Plan:
- Reset then idle: all outputs hold reset values and in_ready=1. Drop reset_n mid-hold → out_valid=0 asynchronously, before the next edge.
- 0x00500093 (ADDI x1,x0,5), rs1_data=0 → next cycle alu_op=`ADD, a=0, b=5, out_rd=1, wb_en=1.
- 0x402081B3 (SUB x3,x1,x2), rs1=10, rs2=3 → `SUB, a=10, b=3, rd=3. Then 0x4030D213 (SRAI x4,x1,3) → `SRA, b=3.
- 0x0020C463 (BLT x1,x2,8) → `LT, is_branch=1, imm=8, wb_en=0. Then 0x123452B7 (LUI x5,0x12345) → a=0, b=32'h12345000.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release → back-to-back loads with no drop or duplicate. With rd=0 → wb_en=0.
- flush asserted on the same edge as an accept → out_valid=0 next cycle. Opcode 7'b1111111 → illegal=1, wb_en=0.
